// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits of the captured operands per
// clock, rippling the carry through a register, and pulses done with the result.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  int unsigned      base;
  logic [CHUNK-1:0] chunk_res;
  logic             chunk_co;
  logic             last_chunk;
  logic             msb_ovf;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    k_d        = k_q;
    c_d        = c_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;

    base                  = int'(k_q) * CHUNK;
    {chunk_co, chunk_res} = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                          + {{CHUNK{1'b0}}, c_q};
    last_chunk            = (k_q == CW'(N - 1));
    // Equal operand signs with a differing result sign is the same as
    // carry-in to the MSB differing from carry-out; b_q is already inverted for sub.
    msb_ovf               = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (chunk_res[CHUNK-1] ^ a_q[WIDTH-1]);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        sum_d[base +: CHUNK] = chunk_res;
        c_d                  = chunk_co;
        if (last_chunk) begin
          carry_d    = chunk_co;
          overflow_d = msb_ovf;
          state_d    = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      k_q        <= '0;
      c_q        <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      k_q        <= k_d;
      c_q        <= c_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Randomized self-checking bench for seq_addsub: a 32/8 instance and a 16/16
// instance, compared against a signed/unsigned arithmetic reference model.
module tb_seq_addsub;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, reset2, start1, start2, sub, cin;
  logic [31:0] a, b;
  logic        busy1, done1, carry1, ovf1;
  logic [31:0] sum1;
  logic        busy2, done2, carry2, ovf2;
  logic [15:0] sum2;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] e_sum;
  logic        e_c, e_v;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ovf1)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .sub(sub), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: true integer arithmetic, then reduce to w bits.
  function automatic void model(input int w, input logic s, input logic [31:0] x, input logic [31:0] y,
                                input logic ci, output logic [31:0] r_sum, output logic r_c,
                                output logic r_v);
    longint m, ux, uy, sx, sy, r;
    m  = longint'(1) << w;
    ux = longint'(x) & (m - 1);
    uy = longint'(y) & (m - 1);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (s) begin
      r     = sx - sy;
      r_c   = (ux >= uy);
      r_sum = 32'((ux - uy + m) % m);
    end else begin
      r     = sx + sy + longint'(ci);
      r_c   = ((ux + uy + longint'(ci)) >= m);
      r_sum = 32'((ux + uy + longint'(ci)) % m);
    end
    r_v = (r >= m / 2) || (r < -(m / 2));
  endfunction

  function automatic logic busy_of(input int sel);  return sel == 0 ? busy1 : busy2;  endfunction
  function automatic logic done_of(input int sel);  return sel == 0 ? done1 : done2;  endfunction
  function automatic logic carry_of(input int sel); return sel == 0 ? carry1 : carry2; endfunction
  function automatic logic ovf_of(input int sel);   return sel == 0 ? ovf1 : ovf2;     endfunction
  function automatic logic [31:0] sum_of(input int sel);
    return sel == 0 ? sum1 : {16'h0, sum2};
  endfunction

  // Called at a negedge: drives operands and start, records the expected result.
  task automatic launch(input int sel, input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic ci);
    sub = s; a = x; b = y; cin = ci;
    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    model(sel == 0 ? 32 : 16, s, x, y, ci, e_sum, e_c, e_v);
  endtask

  // Returns at the negedge where done is seen; optionally disturbs inputs while busy.
  task automatic finish_op(input int sel, input string tag, input bit scramble);
    int  cyc   = 0;
    int  nb    = 0;
    int  n_exp = (sel == 0) ? 4 : 1;
    bit  seen  = 1'b0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      start1 = 1'b0;
      start2 = 1'b0;
      if (done_of(sel)) seen = 1'b1;
      else if (busy_of(sel)) nb++;
      if (!seen && scramble && busy_of(sel)) begin
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
      end
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc - 1), 64'(n_exp));
    check({tag, " busy_cycles"}, 64'(nb), 64'(n_exp));
    check({tag, " sum"}, 64'(sum_of(sel)), 64'(e_sum));
    check({tag, " carry"}, 64'(carry_of(sel)), 64'(e_c));
    check({tag, " overflow"}, 64'(ovf_of(sel)), 64'(e_v));
  endtask

  // One cycle after done with start low: idle, result held.
  task automatic idle_check(input int sel, input string tag);
    @(negedge clk);
    check({tag, " done_pulse_width"}, 64'(done_of(sel)), 64'd0);
    check({tag, " idle_busy"}, 64'(busy_of(sel)), 64'd0);
    check({tag, " sum_hold"}, 64'(sum_of(sel)), 64'(e_sum));
    check({tag, " carry_hold"}, 64'(carry_of(sel)), 64'(e_c));
  endtask

  initial begin
    int ndone;
    reset1 = 1'b1; reset2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy1), 64'd0);
    check("rst done", 64'(done1), 64'd0);
    check("rst sum", 64'(sum1), 64'd0);
    check("rst carry_ovf", 64'({carry1, ovf1}), 64'd0);
    check("rst sum2", 64'(sum2), 64'd0);
    reset1 = 1'b0; reset2 = 1'b0;
    @(negedge clk);

    // Directed corner cases with explicit constants alongside the model.
    launch(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op(0, "add_wrap", 1'b0);
    check("add_wrap const", 64'({sum1, carry1, ovf1}), {32'h0, 32'h0000_0000, 1'b1, 1'b0} >> 0);
    idle_check(0, "add_wrap");

    launch(0, 1'b1, 32'd5, 32'd7, 1'b1);
    finish_op(0, "sub_5_7", 1'b0);
    check("sub_5_7 const", 64'({sum1, carry1, ovf1}), 64'({32'hFFFF_FFFE, 1'b0, 1'b0}));
    idle_check(0, "sub_5_7");

    launch(0, 1'b1, 32'd7, 32'd5, 1'b0);
    finish_op(0, "sub_7_5", 1'b0);
    check("sub_7_5 const", 64'({sum1, carry1}), 64'({32'h0000_0002, 1'b1}));
    idle_check(0, "sub_7_5");

    launch(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op(0, "add_ovf", 1'b0);
    check("add_ovf const", 64'({sum1, carry1, ovf1}), 64'({32'h8000_0000, 1'b0, 1'b1}));
    idle_check(0, "add_ovf");

    launch(0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    finish_op(0, "sub_ovf", 1'b0);
    check("sub_ovf const", 64'({sum1, ovf1}), 64'({32'h7FFF_FFFF, 1'b1}));
    idle_check(0, "sub_ovf");

    // Inputs and start disturbed while busy, then back-to-back start during DONE.
    launch(0, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    finish_op(0, "scramble", 1'b1);
    launch(0, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0);
    finish_op(0, "b2b", 1'b0);
    idle_check(0, "b2b");

    // Reset during the second BUSY cycle aborts with no done pulse.
    launch(0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    reset1 = 1'b1;
    @(negedge clk);
    reset1 = 1'b0;
    check("abort busy", 64'(busy1), 64'd0);
    check("abort done", 64'(done1), 64'd0);
    check("abort sum", 64'(sum1), 64'd0);
    check("abort carry_ovf", 64'({carry1, ovf1}), 64'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("abort no_done", 64'(ndone), 64'd0);

    // Randomized operations, some back-to-back, some disturbed.
    for (int i = 0; i < 24; i++) begin
      launch(0, 1'($urandom), $urandom, $urandom, 1'($urandom));
      finish_op(0, $sformatf("rnd%0d", i), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle_check(0, $sformatf("rnd%0d", i));
    end
    @(negedge clk);

    // Single-chunk instance: done one cycle after start.
    launch(1, 1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1);
    finish_op(1, "n1_wrap", 1'b0);
    check("n1_wrap const", 64'({sum2, carry2}), 64'({16'h0000, 1'b1}));
    idle_check(1, "n1_wrap");
    for (int i = 0; i < 8; i++) begin
      launch(1, 1'($urandom), $urandom, $urandom, 1'($urandom));
      finish_op(1, $sformatf("n1_rnd%0d", i), 1'b0);
    end
    idle_check(1, "n1_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the number of bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-007 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in for add; ignored when sub=1.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking results valid.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port carry, output, 1 bit: carry out of bit WIDTH-1.
REQ-014 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL implement states IDLE, BUSY and DONE; busy=1 only in BUSY and done=1 only in DONE.
REQ-016 In IDLE or DONE with start=1 at a rising edge, the block SHALL capture a, b XOR {WIDTH{sub}}, initial carry = sub ? 1 : cin, and sub, clear the chunk counter to 0, and enter BUSY.
REQ-017 The captured operands SHALL be used for the whole operation; changes on a, b, sub or cin while in BUSY SHALL have no effect.
REQ-018 In BUSY, each rising edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of the captured operands plus the carry register, write the CHUNK-bit result into the same slice of the sum register, store the chunk carry-out into the carry register, and increment k.
REQ-019 On the edge that processes chunk N-1, the block SHALL latch carry = carry out of bit WIDTH-1, latch overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), and enter DONE.
REQ-020 Latency from the start edge to done=1 SHALL be exactly N cycles; with N=1, done SHALL assert the cycle after the start edge.
REQ-021 DONE SHALL last exactly one cycle and return to IDLE unless start=1, in which case it SHALL go directly to BUSY (back-to-back operations).
REQ-022 start SHALL be ignored while in BUSY.
REQ-023 sum, carry and overflow SHALL hold their final values from DONE until the next accepted start; partially updated sum slices while in BUSY are not valid.
REQ-024 For subtract, carry=1 SHALL mean no borrow (a >= b unsigned).
REQ-025 The chunk counter SHALL be wide enough to index N chunks and SHALL never wrap within an operation.

Reset
REQ-026 With reset=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, sum, carry, overflow, the chunk counter and the carry register to 0, regardless of state.
REQ-027 reset SHALL take priority over start; an operation aborted by reset SHALL produce no done pulse.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-028 Test: start, add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> busy for 4 cycles, done 4 cycles after the start edge, sum=0x00000000, carry=1, overflow=0.
REQ-029 Test: start, sub=1, a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, carry=0, overflow=0; then a=7, b=5 -> sum=0x00000002, carry=1.
REQ-030 Test: add, a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, carry=0, overflow=1; then sub, a=0x80000000, b=1 -> sum=0x7FFFFFFF, overflow=1.
REQ-031 Test: change a, b and sub and pulse start during BUSY -> result matches the originally captured operands and only one done pulse occurs; start asserted during DONE -> next done exactly 4 cycles later.
REQ-032 Test: reset asserted during the 2nd BUSY cycle -> next cycle busy=0, done=0, sum=0, and no done pulse follows.
REQ-033 Test: parameters WIDTH=16, CHUNK=16, a=0xFFFF, b=0x0000, cin=1 -> done one cycle after start, sum=0x0000, carry=1.
